// File: rtl/obi_uart.sv
// obi_uart: memory-mapped 8N1 UART on the internal OBI data bus.
//
// State table, TX FSM:
//   state    | meaning
//   TX_IDLE  | line high, waiting for a byte in the TX FIFO
//   TX_START | driving the start bit (0) for one bit time
//   TX_DATA  | shifting out 8 data bits, LSB first
//   TX_STOP  | driving the stop bit (1); may chain straight into the next frame
//
// State table, RX FSM:
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronised line
//   RX_START | waiting half a bit to confirm the start bit
//   RX_DATA  | sampling 8 data bits, one per bit time
//   RX_STOP  | sampling the stop bit, then load or flag a framing error
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   obi_req_i         request (already qualified by block select)
//   obi_gnt_o         registered one-cycle grant
//   obi_addr_i        byte address, bits [3:2] select the register
//   obi_we_i, obi_be_i, obi_wdata_i   write controls and data
//   obi_rvalid_o      response valid, cycle after grant
//   obi_rdata_o       read data, zero outside rvalid and for writes
//   uart_tx_o         serial output, idle high
//   uart_rx_i         serial input, asynchronous
//   irq_o             registered level interrupt
module obi_uart #(
  parameter int SOC_ADDR_WIDTH = 32,
  parameter int CLK_FREQ       = 25_000_000,
  parameter int BAUDRATE       = 115200,
  parameter int TX_FIFO_DEPTH  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      obi_req_i,
  output logic                      obi_gnt_o,
  input  logic [SOC_ADDR_WIDTH-1:0] obi_addr_i,
  input  logic                      obi_we_i,
  input  logic [3:0]                obi_be_i,
  input  logic [31:0]               obi_wdata_i,
  output logic                      obi_rvalid_o,
  output logic [31:0]               obi_rdata_o,
  output logic                      uart_tx_o,
  input  logic                      uart_rx_i,
  output logic                      irq_o
);

  localparam int DIV  = (CLK_FREQ + BAUDRATE / 2) / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------- bus handshake and decode ----------------
  logic        gnt_q, rvalid_q, irq_q;
  logic [31:0] rdata_q, rd_val;
  logic [1:0]  reg_sel, irq_en_q;
  logic        wr_acc, rd_acc, wr_data, wr_irq_en, rd_data, rd_status;

  assign reg_sel   = obi_addr_i[3:2];
  assign wr_acc    = gnt_q & obi_we_i;
  assign rd_acc    = gnt_q & ~obi_we_i;
  assign wr_data   = wr_acc & (reg_sel == 2'd0) & obi_be_i[0];
  assign wr_irq_en = wr_acc & (reg_sel == 2'd2);
  assign rd_data   = rd_acc & (reg_sel == 2'd0);
  assign rd_status = rd_acc & (reg_sel == 2'd1);

  assign obi_gnt_o    = gnt_q;
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign irq_o        = irq_q;

  logic unused_bits;
  assign unused_bits = ^{obi_addr_i[SOC_ADDR_WIDTH-1:4], obi_addr_i[1:0],
                         obi_wdata_i[31:8], obi_be_i[3:1]};

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_q [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        tx_full, tx_empty, tx_pop, push, drop_set;

  assign tx_empty = (wr_ptr_q == rd_ptr_q);
  assign tx_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // the pop in the same cycle frees a slot, so a full FIFO still accepts
  assign push     = wr_data & (~tx_full | tx_pop);
  assign drop_set = wr_data & tx_full & ~tx_pop;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= obi_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (tx_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_line_q, tx_line_d, tx_tc, tx_busy;

  assign tx_tc     = (tx_cnt_q == '0);
  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign uart_tx_o = tx_line_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_q[rd_ptr_q[AW-1:0]];
          tx_cnt_d   = DIV_M1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tc) begin
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_tc) begin
          tx_cnt_d = DIV_M1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_tc) begin
          // chain the next frame without an idle bit
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_q[rd_ptr_q[AW-1:0]];
            tx_cnt_d   = DIV_M1;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // line level follows the next state so the output is a clean flop
    tx_line_d = 1'b1;
    if (tx_state_d == TX_START)     tx_line_d = 1'b0;
    else if (tx_state_d == TX_DATA) tx_line_d = tx_shift_d[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [1:0]  rx_sync_q;
  logic        rx_prev_q, rx_s, rx_tc, rx_load, rx_ferr;

  assign rx_s  = rx_sync_q[1];
  assign rx_tc = (rx_cnt_q == '0);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_load    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_cnt_d   = HALF_M1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_tc) begin
          if (rx_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = DIV_M1;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_tc) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = DIV_M1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_tc) begin
          rx_load    = rx_s;
          rx_ferr    = ~rx_s;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], uart_rx_i};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  // ---------------- status flags ----------------
  logic [7:0] rx_byte_q;
  logic       rx_valid_q, rx_ovr_q, rx_ferr_q, tx_drop_q;

  // new events win over a STATUS read clear: they were not in the returned value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_drop_q  <= 1'b0;
    end else begin
      if (rx_load) begin
        rx_byte_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (rd_data) begin
        rx_valid_q <= 1'b0;
      end
      // a coinciding DATA read consumes the old byte, so no overrun then
      if (rx_load && rx_valid_q && !rd_data) rx_ovr_q <= 1'b1;
      else if (rd_status)                    rx_ovr_q <= 1'b0;
      if (rx_ferr)        rx_ferr_q <= 1'b1;
      else if (rd_status) rx_ferr_q <= 1'b0;
      if (drop_set)       tx_drop_q <= 1'b1;
      else if (rd_status) tx_drop_q <= 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd0:    rd_val = {24'b0, rx_valid_q ? rx_byte_q : 8'h00};
      2'd1:    rd_val = {25'b0, tx_drop_q, rx_ferr_q, rx_ovr_q, rx_valid_q,
                         tx_busy, tx_empty, tx_full};
      2'd2:    rd_val = {30'b0, irq_en_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      gnt_q    <= obi_req_i & ~gnt_q & ~rvalid_q;
      rvalid_q <= gnt_q;
      rdata_q  <= rd_acc ? rd_val : '0;
      if (wr_irq_en) irq_en_q <= obi_wdata_i[1:0];
      irq_q    <= (irq_en_q[0] & rx_valid_q) |
                  (irq_en_q[1] & tx_empty & ~tx_busy);
    end
  end

endmodule

// File: tb/tb_obi_uart.sv
// tb_obi_uart: randomized self-checking bench for obi_uart against a
// register-level reference model (flags, expected TX byte queue).
module tb_obi_uart;
  localparam int CLK_FREQ = 25_000_000;
  localparam int BAUD     = 115200;
  localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int DEPTH    = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        obi_req_i, obi_we_i, uart_rx_i;
  logic [31:0] obi_addr_i, obi_wdata_i;
  logic [3:0]  obi_be_i;
  logic        obi_gnt_o, obi_rvalid_o, uart_tx_o, irq_o;
  logic [31:0] obi_rdata_o;

  obi_uart dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o),
    .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model state
  logic       m_rxv = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_drop = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic [1:0] m_en = 2'b00;
  logic [7:0] exp_q[$];
  logic [8:0] line_q[$];
  int         line_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_stat(input logic full, input logic empty, input logic busy);
    return {25'b0, m_drop, m_ferr, m_ovr, m_rxv, busy, empty, full};
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // line decoder: frames captured as {stop, data} with start cycle
  initial begin : tx_dec
    logic [8:0] fr;
    int st;
    forever begin
      @(posedge clk_i); #1;
      if (rst_ni === 1'b1 && uart_tx_o === 1'b0) begin
        st = cyc;
        repeat (DIV / 2) @(posedge clk_i);
        for (int i = 0; i < 9; i++) begin
          repeat (DIV) @(posedge clk_i);
          #1;
          fr[i] = uart_tx_o;
        end
        line_q.push_back({fr[8], fr[7:0]});
        line_t.push_back(st);
      end
    end
  end

  initial begin : watchdog
    repeat (95_000) @(posedge clk_i);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output int glat);
    int t;
    @(negedge clk_i);
    obi_req_i = 1'b1; obi_we_i = we; obi_addr_i = {28'b0, a, 2'b00};
    obi_wdata_i = wd; obi_be_i = be;
    t = 0;
    do begin @(posedge clk_i); #1; t++; end while (obi_gnt_o !== 1'b1 && t < 20);
    glat = t;
    rd = '0;
    if (obi_gnt_o !== 1'b1) begin
      chk("gnt_timeout", {31'b0, obi_gnt_o}, 32'd1);
      obi_req_i = 1'b0;
    end else begin
      @(posedge clk_i); #1;
      obi_req_i = 1'b0;
      chk("rvalid", {31'b0, obi_rvalid_o}, 32'd1);
      chk("gnt_one_cycle", {31'b0, obi_gnt_o}, 32'd0);
      rd = obi_rdata_o;
      if (we) chk("wr_rdata", rd, 32'd0);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r; int g;
    bus(1'b1, a, d, 4'hF, r, g);
    if (a == 2'd2) m_en = d[1:0];
  endtask

  task automatic rd_stat(input string tag, input logic full, input logic empty, input logic busy);
    logic [31:0] r; int g;
    bus(1'b0, 2'd1, 32'd0, 4'hF, r, g);
    chk(tag, r, exp_stat(full, empty, busy));
    m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] r; int g;
    bus(1'b0, 2'd0, 32'd0, 4'hF, r, g);
    chk(tag, r, m_rxv ? {24'b0, m_byte} : 32'd0);
    m_rxv = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic tx_idle);
    repeat (2) @(negedge clk_i);
    chk(tag, {31'b0, irq_o}, {31'b0, (m_en[0] & m_rxv) | (m_en[1] & tx_idle)});
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    repeat (DIV) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (DIV) @(negedge clk_i);
    end
    uart_rx_i = stop;
    repeat (DIV) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (4) @(negedge clk_i);
    if (stop) begin
      if (m_rxv) m_ovr = 1'b1;
      m_rxv = 1'b1; m_byte = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic wait_tx(input int budget);
    int t;
    t = 0;
    while (line_q.size() < exp_q.size() && t < budget) begin
      @(posedge clk_i);
      t++;
    end
    repeat (DIV) @(posedge clk_i);
  endtask

  task automatic cmp_tx(input string tag);
    chk({tag, "_count"}, line_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < line_q.size(); i++)
      chk(tag, {23'b0, line_q[i]}, {23'b0, 1'b1, exp_q[i]});
    line_q.delete(); line_t.delete(); exp_q.delete();
  endtask

  initial begin : main
    logic [31:0] r;
    int g;
    logic [7:0] b;
    logic s;

    obi_req_i = 1'b0; obi_we_i = 1'b0; obi_addr_i = '0; obi_wdata_i = '0;
    obi_be_i = 4'h0; uart_rx_i = 1'b1; rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_tx", {31'b0, uart_tx_o}, 32'd1);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    chk("rst_gnt", {31'b0, obi_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'b0, obi_rvalid_o}, 32'd0);
    chk("rst_rdata", obi_rdata_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // reset STATUS, grant latency
    bus(1'b0, 2'd1, 32'd0, 4'hF, r, g);
    chk("gnt_latency", g, 32'd1);
    chk("rst_status", r, exp_stat(1'b0, 1'b1, 1'b0));

    // reserved slot and IRQ_EN
    wr(2'd3, 32'hFFFF_FFFF);
    bus(1'b0, 2'd3, 32'd0, 4'hF, r, g);
    chk("reg3_read", r, 32'd0);
    wr(2'd2, 32'h0000_0003);
    bus(1'b0, 2'd2, 32'd0, 4'hF, r, g);
    chk("irq_en_read", r, {30'b0, m_en});
    chk_irq("irq_tx_idle", 1'b1);
    wr(2'd2, 32'd0);
    chk_irq("irq_off", 1'b1);

    // single frame 0x55 with exact bit timing
    wr(2'd0, 32'h0000_0055);
    exp_q.push_back(8'h55);
    fork
      begin : meas
        int t, run;
        logic lvl;
        t = 0;
        do begin @(posedge clk_i); #1; t++; end while (uart_tx_o !== 1'b0 && t < 50);
        chk("tx_start_seen", {31'b0, uart_tx_o}, 32'd0);
        lvl = 1'b0;
        for (int k = 0; k < 9; k++) begin
          run = 1;
          while (run < 2 * DIV) begin
            @(posedge clk_i); #1;
            if (uart_tx_o !== lvl) break;
            run++;
          end
          chk("tx_bit_len", run, DIV);
          lvl = ~lvl;
        end
        run = 1;
        while (run < DIV + 10) begin
          @(posedge clk_i); #1;
          if (uart_tx_o !== 1'b1) break;
          run++;
        end
        chk("tx_stop_high", {31'b0, run >= DIV}, 32'd1);
      end
      begin
        repeat (20) @(negedge clk_i);
        rd_stat("busy_mid", 1'b0, 1'b0 | 1'b1, 1'b1);
      end
    join
    wait_tx(12 * DIV);
    cmp_tx("tx_55");

    // 10 bytes into depth 8: first popped at once, 8 queued, last dropped
    for (int i = 0; i < 10; i++) begin
      wr(2'd0, i);
      if (i <= DEPTH) exp_q.push_back(i[7:0]);
      else            m_drop = 1'b1;
    end
    rd_stat("drop_stat", 1'b1, 1'b0, 1'b1);
    rd_stat("drop_clr", 1'b1, 1'b0, 1'b1);
    wait_tx(10 * DIV * 10 + 200);
    for (int i = 1; i < line_t.size(); i++)
      chk("tx_contig", line_t[i] - line_t[i-1], 10 * DIV);
    cmp_tx("tx_burst");
    rd_stat("burst_idle", 1'b0, 1'b1, 1'b0);

    // RX 0xA3 with rx_valid interrupt
    wr(2'd2, 32'd1);
    send_rx(8'hA3, 1'b1);
    chk_irq("irq_rx", 1'b1);
    rd_stat("rx_stat", 1'b0, 1'b1, 1'b0);
    rd_data("rx_a3");
    chk_irq("irq_rx_clr", 1'b1);

    // overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_stat("ovr_stat", 1'b0, 1'b1, 1'b0);
    rd_data("ovr_data");

    // framing error, then glitch
    send_rx(8'h5A, 1'b0);
    rd_stat("ferr_stat", 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    repeat (50) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (DIV) @(negedge clk_i);
    rd_stat("glitch_stat", 1'b0, 1'b1, 1'b0);
    send_rx(8'hC5, 1'b1);
    rd_data("after_glitch");

    // randomized RX traffic
    for (int it = 0; it < 4; it++) begin
      wr(2'd2, $urandom_range(0, 3));
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_rx(b, s);
      chk_irq("rnd_irq", 1'b1);
      case ($urandom_range(0, 2))
        0: rd_data("rnd_data");
        1: rd_stat("rnd_stat", 1'b0, 1'b1, 1'b0);
        default: ;
      endcase
    end
    rd_stat("rnd_final_stat", 1'b0, 1'b1, 1'b0);
    rd_data("rnd_final_data");

    // randomized TX traffic; a DATA write without be[0] is ignored
    for (int it = 0; it < 3; it++) begin
      b = 8'($urandom_range(0, 255));
      wr(2'd0, {24'hABCDEF, b});
      exp_q.push_back(b);
    end
    bus(1'b1, 2'd0, 32'h0000_00AA, 4'hE, r, g);
    wait_tx(10 * DIV * 4 + 200);
    cmp_tx("tx_rnd");

    // reset in the middle of a TX and an RX frame
    wr(2'd0, 32'h0000_00F0);
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    repeat (3 * DIV) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_tx", {31'b0, uart_tx_o}, 32'd1);
    chk("midrst_irq", {31'b0, irq_o}, 32'd0);
    uart_rx_i = 1'b1;
    m_rxv = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0; m_en = 2'b00;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (12 * DIV) @(negedge clk_i);
    line_q.delete(); line_t.delete(); exp_q.delete();
    chk("midrst_line", {31'b0, uart_tx_o}, 32'd1);
    rd_stat("midrst_stat", 1'b0, 1'b1, 1'b0);
    rd_data("midrst_data");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
